// File: rtl/stack_if.sv
// stack_if: controller-side request/status bundle for stack_ctrl; clr exists only with STACK_CTRL_CLR_EN.
interface stack_if #(parameter int DATA_W = 8, parameter int ADDR_W = 4);
    logic              push, pop, tos;
    logic [DATA_W-1:0] din, dout;
    logic              rvalid, busy;
    logic [ADDR_W:0]   sp;
    logic              empty, full, ovf, udf, ill;
`ifdef STACK_CTRL_CLR_EN
    logic              clr;
`endif
    modport master (
`ifdef STACK_CTRL_CLR_EN
        output clr,
`endif
        output push, pop, tos, din,
        input  dout, rvalid, busy, sp, empty, full, ovf, udf, ill
    );
    modport slave (
`ifdef STACK_CTRL_CLR_EN
        input  clr,
`endif
        input  push, pop, tos, din,
        output dout, rvalid, busy, sp, empty, full, ovf, udf, ill
    );
endinterface

// File: rtl/stack_ctrl.sv
// stack_ctrl: stack pointer and request sequencer for a single-port sync-read stack RAM.
// Optional STACK_CTRL_CLR_EN adds a clr input that empties the stack without RAM access.
module stack_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    stack_if.slave            bus,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata
);
    localparam int DEPTH = 2 ** ADDR_W;
    typedef enum logic {IDLE, CAP} state_t;
    state_t            state;
    logic [ADDR_W:0]   sp, sp_dec;
    logic [DATA_W-1:0] dout;
    logic              rvalid, busy, ovf, udf, ill, empty, full;
    logic              clr, live, one, rd, do_push, do_rd;
    logic [1:0]        nreq;
`ifdef STACK_CTRL_CLR_EN
    assign clr = bus.clr;
`else
    assign clr = 1'b0;
`endif
    always_comb begin
        empty     = sp == '0;
        full      = sp == (ADDR_W + 1)'(DEPTH);
        sp_dec    = sp - 1'b1;
        nreq      = 2'(bus.push) + 2'(bus.pop) + 2'(bus.tos);
        live      = state == IDLE && !clr;
        one       = live && nreq == 2'd1;
        rd        = bus.pop || bus.tos;
        do_push   = one && bus.push && !full;
        do_rd     = one && rd && !empty;
        ram_we    = do_push;
        ram_re    = do_rd;
        ram_addr  = do_push ? sp[ADDR_W-1:0] : do_rd ? sp_dec[ADDR_W-1:0] : '0;
        ram_wdata = do_push ? bus.din : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sp     <= '0;
            dout   <= '0;
            rvalid <= 1'b0;
            busy   <= 1'b0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
            ill    <= 1'b0;
        end else begin
            state  <= do_rd ? CAP : IDLE;
            busy   <= do_rd;
            rvalid <= state == CAP;
            if (state == CAP) dout <= ram_rdata;
            // clr wins over everything, including finishing a capture with sp cleared
            if (clr) sp <= '0;
            else if (do_push) sp <= sp + 1'b1;
            else if (do_rd && bus.pop) sp <= sp_dec;
            if (one && bus.push && full) ovf <= 1'b1;
            if (one && rd && empty) udf <= 1'b1;
            if (live && nreq > 2'd1) ill <= 1'b1;
        end
    end
    assign bus.sp     = sp;
    assign bus.dout   = dout;
    assign bus.rvalid = rvalid;
    assign bus.busy   = busy;
    assign bus.empty  = empty;
    assign bus.full   = full;
    assign bus.ovf    = ovf;
    assign bus.udf    = udf;
    assign bus.ill    = ill;
endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed stimulus against a queue-based stack model plus a RAM model.
module tb_stack_ctrl;
    logic clk = 1'b0, rst = 1'b1, clr_v = 1'b0;
    always #5 clk = ~clk;
    stack_if #(.DATA_W(8), .ADDR_W(4)) bus();
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata, ram_rdata;
    logic       ram_we, ram_re;
    logic [7:0] mem [16];
`ifdef STACK_CTRL_CLR_EN
    assign bus.clr = clr_v;
`endif
    stack_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .bus(bus), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata)
    );
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end
    int checks = 0, errors = 0;
    bit run = 0;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // model: the stack itself is a queue; a pending read is remembered by value
    logic [7:0] q[$];
    logic [7:0] m_dout = 8'h00, m_pend = 8'h00;
    bit m_cap = 0, m_rv = 0, m_ovf = 0, m_udf = 0, m_ill = 0;
    initial forever begin
        int n, sz;
        bit acc, ew, er;
        @(negedge clk);
        n   = int'(bus.push) + int'(bus.pop) + int'(bus.tos);
        sz  = q.size();
        acc = !m_cap && !clr_v && n == 1;
        ew  = acc && bus.push && sz < 16;
        er  = acc && (bus.pop || bus.tos) && sz > 0;
        if (run) begin
            chk("sp", 32'(bus.sp), 32'(sz));
            chk("empty", 32'(bus.empty), 32'(sz == 0));
            chk("full", 32'(bus.full), 32'(sz == 16));
            chk("busy", 32'(bus.busy), 32'(m_cap));
            chk("rvalid", 32'(bus.rvalid), 32'(m_rv));
            chk("dout", 32'(bus.dout), 32'(m_dout));
            chk("ovf", 32'(bus.ovf), 32'(m_ovf));
            chk("udf", 32'(bus.udf), 32'(m_udf));
            chk("ill", 32'(bus.ill), 32'(m_ill));
            if (!rst) begin
                chk("ram_we", 32'(ram_we), 32'(ew));
                chk("ram_re", 32'(ram_re), 32'(er));
                chk("ram_addr", 32'(ram_addr), ew ? 32'(sz) : er ? 32'(sz - 1) : 32'd0);
                chk("ram_wdata", 32'(ram_wdata), ew ? 32'(bus.din) : 32'd0);
            end
        end
        if (rst) begin
            q.delete();
            m_dout = 8'h00; m_cap = 0; m_rv = 0; m_ovf = 0; m_udf = 0; m_ill = 0;
        end else if (m_cap) begin
            m_dout = m_pend; m_rv = 1; m_cap = 0;
            if (clr_v) q.delete();
        end else begin
            m_rv = 0;
            if (clr_v) q.delete();
            else if (n > 1) m_ill = 1;
            else if (bus.push) begin
                if (sz == 16) m_ovf = 1; else q.push_back(bus.din);
            end else if (bus.pop || bus.tos) begin
                if (sz == 0) m_udf = 1;
                else begin
                    m_pend = q[sz-1];
                    m_cap  = 1;
                    if (bus.pop) void'(q.pop_back());
                end
            end
        end
    end
    task automatic req(bit p, bit o, bit t, logic [7:0] d, bit c = 0);
        bus.push = p; bus.pop = o; bus.tos = t; bus.din = d; clr_v = c;
        @(posedge clk); #1;
        bus.push = 0; bus.pop = 0; bus.tos = 0; bus.din = 8'h00; clr_v = 0;
    endtask
    task automatic idle(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    initial begin
        bus.push = 0; bus.pop = 0; bus.tos = 0; bus.din = 8'h00;
        idle(2);
        rst = 0; run = 1;
        chk("reset_sp", 32'(bus.sp), 32'd0);
        chk("reset_empty", 32'(bus.empty), 32'd1);
        req(1, 0, 0, 8'h11); req(1, 0, 0, 8'h22); req(1, 0, 0, 8'h33);
        chk("push3_sp", 32'(bus.sp), 32'd3);
        chk("push3_mem2", 32'(mem[2]), 32'h33);
        req(0, 0, 1, 8'h00);
        chk("tos_busy", 32'(bus.busy), 32'd1);
        idle(1);
        chk("tos_dout", 32'(bus.dout), 32'h33);
        chk("tos_rvalid", 32'(bus.rvalid), 32'd1);
        chk("tos_sp", 32'(bus.sp), 32'd3);
        idle(1);
        chk("tos_rvalid_off", 32'(bus.rvalid), 32'd0);
        req(0, 1, 0, 8'h00); idle(1); chk("pop1", 32'(bus.dout), 32'h33);
        req(0, 1, 0, 8'h00); idle(1); chk("pop2", 32'(bus.dout), 32'h22);
        req(0, 1, 0, 8'h00); idle(1); chk("pop3", 32'(bus.dout), 32'h11);
        chk("pop_empty", 32'(bus.empty), 32'd1);
        req(0, 1, 0, 8'h00);
        chk("udf_set", 32'(bus.udf), 32'd1);
        chk("udf_dout", 32'(bus.dout), 32'h11);
        chk("udf_busy", 32'(bus.busy), 32'd0);
        req(1, 0, 0, 8'h44);
        chk("push44_sp", 32'(bus.sp), 32'd1);
        for (int i = 1; i < 16; i++) req(1, 0, 0, 8'(i));
        chk("full", 32'(bus.full), 32'd1);
        req(1, 0, 0, 8'hFF);
        chk("ovf_set", 32'(bus.ovf), 32'd1);
        chk("ovf_sp", 32'(bus.sp), 32'd16);
        req(0, 1, 0, 8'h00); idle(1);
        chk("pop_top16", 32'(bus.dout), 32'h0F);
        repeat (13) begin req(0, 1, 0, 8'h00); idle(1); end
        chk("sp2", 32'(bus.sp), 32'd2);
        req(1, 1, 0, 8'h55);
        chk("ill_set", 32'(bus.ill), 32'd1);
        chk("ill_sp", 32'(bus.sp), 32'd2);
        req(0, 1, 0, 8'h00);
        req(1, 0, 0, 8'hAA);
        chk("cap_push_ignored", 32'(bus.sp), 32'd1);
        chk("cap_dout", 32'(bus.dout), 32'h01);
        req(0, 0, 1, 8'h00);
        rst = 1; idle(1); rst = 0;
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_sp", 32'(bus.sp), 32'd0);
        chk("rst_dout", 32'(bus.dout), 32'd0);
        chk("rst_flags", 32'({bus.ovf, bus.udf, bus.ill}), 32'd0);
        idle(1);
`ifdef STACK_CTRL_CLR_EN
        for (int i = 0; i < 5; i++) req(1, 0, 0, 8'(8'h60 + i));
        chk("clr_pre", 32'(bus.sp), 32'd5);
        req(1, 0, 0, 8'h77, 1);
        chk("clr_sp", 32'(bus.sp), 32'd0);
        chk("clr_ill", 32'(bus.ill), 32'd0);
        req(1, 0, 0, 8'h81); req(1, 0, 0, 8'h82);
        req(0, 1, 0, 8'h00);
        req(0, 0, 0, 8'h00, 1);
        chk("clr_cap_dout", 32'(bus.dout), 32'h82);
        chk("clr_cap_sp", 32'(bus.sp), 32'd0);
        idle(1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
